// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage of the 5-stage 32-bit RISC pipeline. It owns the program
//   counter, drives a synchronous instruction memory with a 1-cycle read
//   latency, and hands a registered instruction, its PC and a valid flag to
//   the decode stage.
//
//   Decode-side stalls are absorbed by a one-entry skid register. While
//   stalled, the memory keeps returning data for the held fetch address, not
//   for the in-flight one. The word that arrives on the first stall cycle is
//   therefore parked until the stall releases.
//
//   A redirect (taken branch/jump) flushes everything in flight and restarts
//   fetch at the word-aligned target. A redirect has priority over a stall.
//
// Ports
//   clk          : pipeline clock, rising edge
//   reset        : asynchronous, active-high reset
//   stall        : decode cannot accept; hold the fetch outputs
//   redirect     : taken branch/jump; flush and refetch
//   redirect_pc  : target PC, sampled when redirect = 1
//   imem_addr    : instruction memory address (the fetch_pc register)
//   imem_rdata   : memory data for the address presented last cycle
//   if_instr     : registered instruction word to the decoder
//   if_pc        : registered PC of if_instr
//   if_valid     : if_instr/if_pc carry a real instruction
//   misalign_err : sticky flag; some redirect target had bits [1:0] != 0
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        misalign_err
);

  // Address being presented to memory this cycle.
  logic [31:0] fetch_pc;
  // Address presented last cycle. Its data is on imem_rdata now.
  logic [31:0] pend_pc;
  logic        pend_valid;
  // Skid entry that holds the pend_pc data captured on the first stall cycle.
  logic [31:0] hold_instr;
  logic        hold_valid;

  // The word that would move into the decode register on an advance.
  // The skid copy wins over the live memory data. When nothing is in
  // flight, a NOP is inserted instead.
  logic [31:0] advance_instr;

  assign imem_addr = fetch_pc;

  always_comb begin
    advance_instr = NOP_INSTR;
    if (pend_valid) begin
      advance_instr = hold_valid ? hold_instr : imem_rdata;
    end
  end

  // Single sequential process for the whole stage. The priority order is
  // reset, then redirect, then stall, then the normal advance. A redirect
  // raised together with a stall release must still discard the skid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      pend_pc      <= '0;
      pend_valid   <= 1'b0;
      hold_instr   <= '0;
      hold_valid   <= 1'b0;
      if_instr     <= NOP_INSTR;
      if_pc        <= '0;
      if_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect) begin
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      pend_valid <= 1'b0;
      hold_valid <= 1'b0;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_pc      <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
    end else if (stall) begin
      // Capture only on the first stall cycle. Later cycles return data for
      // fetch_pc, which must not overwrite the parked word.
      if (!hold_valid && pend_valid) begin
        hold_instr <= imem_rdata;
        hold_valid <= 1'b1;
      end
    end else begin
      if_instr   <= advance_instr;
      if_pc      <= pend_pc;
      if_valid   <= pend_valid;
      pend_pc    <= fetch_pc;
      pend_valid <= 1'b1;
      fetch_pc   <= fetch_pc + 32'd4;
      hold_valid <= 1'b0;
    end
  end

endmodule
